// File: rtl/hex_output_port.sv
// Latches processor output-port writes into NUM_CH channels and shows one of them on
// active-low 7-segment digits, in hex or in unsigned decimal via a sequential shift-add-3 converter.
module hex_output_port #(
  parameter int DATA_W     = 16,
  parameter int NUM_CH     = 4,
  parameter int NUM_DIGITS = 5,
  parameter int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                       CLOCK_50,
  input  logic                       rst_n,
  input  logic                       wr_en,
  input  logic [CH_W-1:0]            wr_ch,
  input  logic [DATA_W-1:0]          wr_data,
  input  logic [CH_W-1:0]            disp_ch,
  input  logic                       dec_mode,
  input  logic                       blank,
  output logic [7*NUM_DIGITS-1:0]    hex_out,
  output logic [NUM_CH*DATA_W-1:0]   ch_data,
  output logic [NUM_CH-1:0]          valid,
  output logic                       busy
);

  localparam int HEX_DIGITS = (DATA_W + 3) / 4;
  localparam int BCD_W      = 4 * NUM_DIGITS;
  localparam int CNT_W      = $clog2(DATA_W + 1);
  localparam logic [6:0] SEG_DASH = 7'b0111111;
  localparam logic [6:0] SEG_DARK = 7'b1111111;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SHIFT, S_DONE} state_t;

  state_t                  state_q, state_d;
  logic [DATA_W-1:0]       ch_q [NUM_CH];
  logic [DATA_W-1:0]       ch_d [NUM_CH];
  logic [NUM_CH-1:0]       valid_q, valid_d;
  logic [DATA_W-1:0]       snap_val_q, snap_val_d;
  logic [CH_W-1:0]         snap_ch_q, snap_ch_d;
  logic                    snap_mode_q, snap_mode_d;
  logic                    snap_valid_q, snap_valid_d;
  logic [DATA_W-1:0]       sreg_q, sreg_d;
  logic [BCD_W-1:0]        bcd_q, bcd_d, bcd_adj;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [7*NUM_DIGITS-1:0] disp_q, disp_d, digits;
  logic [DATA_W-1:0]       live_val;
  logic                    live_vld;
  logic                    req;
  logic [BCD_W-1:0]        val_pad;
  logic                    seen_nz;

  function automatic logic [6:0] seg7(input logic [3:0] n);
    case (n)
      4'h0: seg7 = 7'b1000000;
      4'h1: seg7 = 7'b1111001;
      4'h2: seg7 = 7'b0100100;
      4'h3: seg7 = 7'b0110000;
      4'h4: seg7 = 7'b0011001;
      4'h5: seg7 = 7'b0010010;
      4'h6: seg7 = 7'b0000010;
      4'h7: seg7 = 7'b1111000;
      4'h8: seg7 = 7'b0000000;
      4'h9: seg7 = 7'b0010000;
      4'hA: seg7 = 7'b0001000;
      4'hB: seg7 = 7'b0000011;
      4'hC: seg7 = 7'b1000110;
      4'hD: seg7 = 7'b0100001;
      4'hE: seg7 = 7'b0000110;
      default: seg7 = 7'b0001110;
    endcase
  endfunction

  function automatic logic [BCD_W-1:0] add3(input logic [BCD_W-1:0] b);
    logic [BCD_W-1:0] r;
    r = b;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (b[4*i +: 4] >= 4'd5) r[4*i +: 4] = b[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

  // Channel write path; out-of-range channel indices match no entry and are dropped.
  always_comb begin
    ch_d    = ch_q;
    valid_d = valid_q;
    for (int i = 0; i < NUM_CH; i++) begin
      if (wr_en && (wr_ch == CH_W'(i))) begin
        ch_d[i]    = wr_data;
        valid_d[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CH; i++) ch_q[i] <= '0;
      valid_q <= '0;
    end else begin
      ch_q    <= ch_d;
      valid_q <= valid_d;
    end
  end

  always_comb begin
    ch_data = '0;
    for (int i = 0; i < NUM_CH; i++) ch_data[i*DATA_W +: DATA_W] = ch_q[i];
  end
  assign valid = valid_q;

  always_comb begin
    live_val = '0;
    live_vld = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (disp_ch == CH_W'(i)) begin
        live_val = ch_q[i];
        live_vld = valid_q[i];
      end
    end
  end

  assign req = (live_val != snap_val_q) || (disp_ch != snap_ch_q) ||
               (dec_mode != snap_mode_q) || (live_vld != snap_valid_q);

  always_ff @(posedge CLOCK_50) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (req) state_d = S_LOAD;
      S_LOAD:  state_d = (snap_mode_q && snap_valid_q) ? S_SHIFT : S_DONE;
      S_SHIFT: if (cnt_q == CNT_W'(DATA_W - 1)) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q != S_IDLE);
  end

  // Digit image from the snapshot; decimal blanks zeros above the top nonzero digit.
  always_comb begin
    val_pad                = '0;
    val_pad[DATA_W-1:0]    = snap_val_q;
    seen_nz                = 1'b0;
    digits                 = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      if (!snap_valid_q) begin
        digits[7*i +: 7] = SEG_DASH;
      end else if (!snap_mode_q) begin
        digits[7*i +: 7] = (i < HEX_DIGITS) ? seg7(val_pad[4*i +: 4]) : SEG_DARK;
      end else begin
        seen_nz          = seen_nz || (bcd_q[4*i +: 4] != 4'd0);
        digits[7*i +: 7] = (seen_nz || i == 0) ? seg7(bcd_q[4*i +: 4]) : SEG_DARK;
      end
    end
  end

  always_comb begin
    snap_val_d   = snap_val_q;
    snap_ch_d    = snap_ch_q;
    snap_mode_d  = snap_mode_q;
    snap_valid_d = snap_valid_q;
    sreg_d       = sreg_q;
    bcd_d        = bcd_q;
    cnt_d        = cnt_q;
    disp_d       = disp_q;
    bcd_adj      = add3(bcd_q);
    case (state_q)
      S_IDLE: begin
        if (req) begin
          snap_val_d   = live_val;
          snap_ch_d    = disp_ch;
          snap_mode_d  = dec_mode;
          snap_valid_d = live_vld;
        end
      end
      S_LOAD: begin
        bcd_d  = '0;
        sreg_d = snap_val_q;
        cnt_d  = '0;
      end
      S_SHIFT: begin
        bcd_d  = {bcd_adj[BCD_W-2:0], sreg_q[DATA_W-1]};
        sreg_d = sreg_q << 1;
        cnt_d  = cnt_q + CNT_W'(1);
      end
      S_DONE: disp_d = digits;
      default: ;
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (!rst_n) begin
      snap_val_q   <= '0;
      snap_ch_q    <= '0;
      snap_mode_q  <= 1'b0;
      snap_valid_q <= 1'b0;
      sreg_q       <= '0;
      bcd_q        <= '0;
      cnt_q        <= '0;
      disp_q       <= {NUM_DIGITS{SEG_DASH}};
    end else begin
      snap_val_q   <= snap_val_d;
      snap_ch_q    <= snap_ch_d;
      snap_mode_q  <= snap_mode_d;
      snap_valid_q <= snap_valid_d;
      sreg_q       <= sreg_d;
      bcd_q        <= bcd_d;
      cnt_q        <= cnt_d;
      disp_q       <= disp_d;
    end
  end

  assign hex_out = blank ? '1 : disp_q;

endmodule

// File: tb/tb_hex_output_port.sv
// Bench for hex_output_port: vector table, timed corner sequences and randomized traffic
// compared against an arithmetic display model.
module tb_hex_output_port;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wr_en;
  logic [1:0]  wr_ch;
  logic [15:0] wr_data;
  logic [1:0]  disp_ch;
  logic        dec_mode;
  logic        blank;
  logic [34:0] hex_out;
  logic [63:0] ch_data;
  logic [3:0]  valid;
  logic        busy;

  logic        wr_en3;
  logic [1:0]  wr_ch3;
  logic [15:0] wr_data3;
  logic [34:0] hex_out3;
  logic [47:0] ch_data3;
  logic [2:0]  valid3;
  logic        busy3;

  int checks = 0;
  int errors = 0;

  logic [15:0] ch_m [4];
  logic        v_m  [4];

  localparam logic [6:0] SEG [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                      7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  localparam logic [34:0] DASHES = {5{7'h3F}};

  hex_output_port dut (
    .CLOCK_50(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_ch(wr_ch), .wr_data(wr_data),
    .disp_ch(disp_ch), .dec_mode(dec_mode), .blank(blank), .hex_out(hex_out),
    .ch_data(ch_data), .valid(valid), .busy(busy)
  );

  hex_output_port #(.NUM_CH(3)) dut3 (
    .CLOCK_50(clk), .rst_n(rst_n), .wr_en(wr_en3), .wr_ch(wr_ch3), .wr_data(wr_data3),
    .disp_ch(2'd0), .dec_mode(1'b0), .blank(1'b0), .hex_out(hex_out3),
    .ch_data(ch_data3), .valid(valid3), .busy(busy3)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] val;
    logic        mode;
    logic [34:0] exp;
  } vec_t;
  vec_t tbl [8];

  function automatic logic [34:0] model(input logic [15:0] v, input logic m, input logic vl);
    logic [34:0] r;
    int p;
    r = '0;
    if (!vl) return DASHES;
    p = 1;
    for (int i = 0; i < 5; i++) begin
      if (!m) r[7*i +: 7] = (i < 4) ? SEG[4'((int'(v) >> (4*i)) & 15)] : 7'h7F;
      else    r[7*i +: 7] = (i == 0 || int'(v) >= p) ? SEG[4'((int'(v) / p) % 10)] : 7'h7F;
      p = p * 10;
    end
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int c, input logic [15:0] d);
    wr_en   = 1'b1;
    wr_ch   = 2'(c);
    wr_data = d;
    tick();
    wr_en   = 1'b0;
    ch_m[c] = d;
    v_m[c]  = 1'b1;
  endtask

  // Waits until busy has stayed low for three consecutive samples, bounded.
  task automatic settle();
    int quiet = 0;
    int n = 0;
    while (quiet < 3 && n < 300) begin
      tick();
      n++;
      if (busy) quiet = 0;
      else quiet++;
    end
    chk("settle_timeout", 64'(quiet >= 3), 64'd1);
  endtask

  initial begin
    logic        flag;
    logic [34:0] e7, e12345, e9, eprev;

    tbl[0] = '{16'h0000, 1'b0, {7'h7F, 7'h40, 7'h40, 7'h40, 7'h40}};
    tbl[1] = '{16'd0,    1'b1, {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40}};
    tbl[2] = '{16'd10000,1'b1, {7'h79, 7'h40, 7'h40, 7'h40, 7'h40}};
    tbl[3] = '{16'd100,  1'b1, {7'h7F, 7'h7F, 7'h79, 7'h40, 7'h40}};
    tbl[4] = '{16'hFFFF, 1'b0, {7'h7F, 7'h0E, 7'h0E, 7'h0E, 7'h0E}};
    tbl[5] = '{16'd9090, 1'b1, {7'h7F, 7'h10, 7'h40, 7'h10, 7'h40}};
    tbl[6] = '{16'h8001, 1'b0, {7'h7F, 7'h00, 7'h40, 7'h40, 7'h79}};
    tbl[7] = '{16'hC3D5, 1'b0, {7'h7F, 7'h46, 7'h30, 7'h21, 7'h12}};

    for (int i = 0; i < 4; i++) begin ch_m[i] = '0; v_m[i] = 1'b0; end
    rst_n = 1'b0; wr_en = 1'b0; wr_ch = '0; wr_data = '0;
    disp_ch = '0; dec_mode = 1'b0; blank = 1'b0;
    wr_en3 = 1'b0; wr_ch3 = '0; wr_data3 = '0;
    tick(); tick();
    rst_n = 1'b1;

    // Quiet after reset: no request, dashes persist.
    flag = 1'b0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (busy || hex_out !== DASHES) flag = 1'b1;
    end
    chk("reset_quiet", 64'(flag), 64'd0);
    chk("reset_hex", 64'(hex_out), 64'(DASHES));
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_valid", 64'(valid), 64'd0);
    chk("reset_ch_data", ch_data, 64'd0);

    // Hex write to displayed channel: display updates on edge 3.
    wr(0, 16'h1A2F);
    chk("w_ch_data", 64'(ch_data[15:0]), 64'h1A2F);
    chk("w_valid", 64'(valid), 64'b0001);
    chk("hex_busy_e0", 64'(busy), 64'd0);
    tick();
    chk("hex_busy_e1", 64'(busy), 64'd1);
    tick();
    chk("hex_busy_e2", 64'(busy), 64'd1);
    chk("hex_old_e2", 64'(hex_out), 64'(DASHES));
    tick();
    chk("hex_1A2F_e3", 64'(hex_out), 64'({7'h7F, 7'h79, 7'h08, 7'h24, 7'h0E}));
    chk("hex_busy_e3", 64'(busy), 64'd0);

    dec_mode = 1'b1;
    settle();
    chk("dec_1A2F", 64'(hex_out), 64'(model(16'h1A2F, 1'b1, 1'b1)));
    eprev = hex_out;

    wr(0, 16'd65535);
    for (int e = 1; e <= 18; e++) tick();
    chk("dec_65535_e18", 64'(hex_out), 64'(eprev));
    tick();
    chk("dec_65535_e19", 64'(hex_out), 64'({7'h02, 7'h12, 7'h12, 7'h30, 7'h12}));
    settle();

    wr(0, 16'd7);
    settle();
    chk("dec_7", 64'(hex_out), 64'({7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h78}));

    // Write during SHIFT: first result completes, then a fresh conversion, nothing in between.
    e7     = model(16'd7, 1'b1, 1'b1);
    e12345 = model(16'd12345, 1'b1, 1'b1);
    e9     = model(16'd9, 1'b1, 1'b1);
    wr(0, 16'd12345);
    for (int e = 1; e <= 6; e++) tick();
    wr(0, 16'd9);
    chk("mid_ch_data", 64'(ch_data[15:0]), 64'd9);
    flag = 1'b0;
    for (int e = 8; e <= 45; e++) begin
      tick();
      if (hex_out !== e7 && hex_out !== e12345 && hex_out !== e9) flag = 1'b1;
      if (e == 18) chk("mid_e18", 64'(hex_out), 64'(e7));
      if (e == 19) chk("mid_e19", 64'(hex_out), 64'(e12345));
      if (e == 37) chk("mid_e37", 64'(hex_out), 64'(e12345));
      if (e == 38) chk("mid_e38", 64'(hex_out), 64'(e9));
    end
    chk("mid_no_glitch", 64'(flag), 64'd0);

    for (int i = 0; i < 8; i++) begin
      dec_mode = tbl[i].mode;
      wr(0, tbl[i].val);
      settle();
      chk($sformatf("tbl_%0d", i), 64'(hex_out), 64'(tbl[i].exp));
    end

    // Non-displayed channel write does not convert; switching disp_ch does.
    dec_mode = 1'b0;
    settle();
    eprev = hex_out;
    wr(2, 16'hBEEF);
    flag = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (busy) flag = 1'b1;
    end
    chk("beef_no_conv", 64'(flag), 64'd0);
    chk("beef_hold", 64'(hex_out), 64'(eprev));
    chk("beef_valid", 64'(valid), 64'b0101);
    disp_ch = 2'd2;
    tick(); tick();
    chk("beef_e2", 64'(hex_out), 64'(eprev));
    tick();
    chk("beef_e3", 64'(hex_out), 64'({7'h7F, 7'h03, 7'h06, 7'h06, 7'h0E}));
    settle();

    wr_en3 = 1'b1; wr_ch3 = 2'd3; wr_data3 = 16'h1234;
    tick();
    wr_en3 = 1'b0;
    chk("ch3_ignored_valid", 64'(valid3), 64'd0);
    chk("ch3_ignored_data", 64'(ch_data3), 64'd0);
    wr_en3 = 1'b1; wr_ch3 = 2'd2; wr_data3 = 16'h5A5A;
    tick();
    wr_en3 = 1'b0;
    chk("ch3_ch2_valid", 64'(valid3), 64'b100);
    chk("ch3_ch2_data", 64'(ch_data3), {16'h0, 16'h5A5A, 32'h0});

    // blank overrides combinationally, even mid-conversion.
    disp_ch = 2'd0;
    wr(0, 16'h4321);
    tick();
    blank = 1'b1;
    #1;
    chk("blank_busy_conv", 64'(hex_out), 64'({35{1'b1}}));
    blank = 1'b0;
    #1;
    settle();
    chk("unblank", 64'(hex_out), 64'(model(16'h4321, 1'b0, 1'b1)));

    for (int it = 0; it < 40; it++) begin
      int nw;
      nw = $urandom_range(1, 3);
      for (int k = 0; k < nw; k++) wr(int'($urandom_range(0, 3)), 16'($urandom));
      disp_ch  = 2'($urandom_range(0, 3));
      dec_mode = 1'($urandom_range(0, 1));
      settle();
      blank = ($urandom_range(0, 3) == 0);
      #1;
      chk($sformatf("rnd_hex_%0d", it), 64'(hex_out),
          64'(blank ? {35{1'b1}} : model(ch_m[disp_ch], dec_mode, v_m[disp_ch])));
      chk($sformatf("rnd_data_%0d", it), ch_data, {ch_m[3], ch_m[2], ch_m[1], ch_m[0]});
      chk($sformatf("rnd_valid_%0d", it), 64'(valid), 64'({v_m[3], v_m[2], v_m[1], v_m[0]}));
      blank = 1'b0;
    end

    // Reset aborts a decimal conversion in progress.
    disp_ch  = 2'd0;
    dec_mode = 1'b1;
    settle();
    wr(0, ch_m[0] ^ 16'h0001);
    for (int e = 1; e <= 5; e++) tick();
    chk("pre_rst_busy", 64'(busy), 64'd1);
    rst_n = 1'b0;
    tick();
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_hex", 64'(hex_out), 64'(DASHES));
    chk("rst_valid", 64'(valid), 64'd0);
    chk("rst_ch_data", ch_data, 64'd0);
    rst_n = 1'b1;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
